// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg
//   Shared definitions for the serial word collector: FSM state encoding,
//   bit-order constants and default word/FIFO geometry.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PARITY  = 2'd2
    } state_t;

    // Value of dir_left that selects each bit order.
    typedef enum logic {
        DIR_LSB_FIRST = 1'b0,
        DIR_MSB_FIRST = 1'b1
    } dir_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/word_fifo.sv
// word_fifo
//   Small synchronous FIFO holding completed words until the consumer takes them.
//   A push while full is accepted only if a pop happens in the same cycle.
//   Ports:
//     clk, reset       clock, asynchronous active-low reset
//     push, push_data  write request and word
//     pop              read request (ignored when empty)
//     full, empty      occupancy flags derived from the entry count
//     head             oldest word, 0 when empty
module word_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the head that is leaving this cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// serial_word_collector
//   Reassembles WIDTH-bit words from a serial bit stream (one bit per bit_valid),
//   MSB-first or LSB-first, and queues them in word_fifo behind a valid/ready port.
//   Optional feature macro: PARITY_CHECK_EN adds an even-parity bit after each word.
//   Ports:
//     clk, reset            clock, asynchronous active-low reset
//     bit_valid, bit_in     serial bit strobe and data
//     dir_left              1 = MSB first, 0 = LSB first (sampled with bit_valid)
//     flush                 drop the partial word (wins over bit_valid)
//     out_valid/ready/data  FIFO head handshake
//     overflow, clr_flags   sticky dropped-word flag and its clear
//     dir_err, parity_err   one-cycle error pulses
//
//   state      | meaning
//   ST_IDLE    | no partial word held
//   ST_COLLECT | 1..WIDTH-1 data bits held
//   ST_PARITY  | full word held, waiting for parity bit (PARITY_CHECK_EN only)
module serial_word_collector
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             dir_left,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow,
    output logic             dir_err,
    output logic             parity_err,
    input  logic             clr_flags
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    dir_t             dir_q, dir_d;
    dir_t             cur_dir;
    logic [WIDTH-1:0] acc_new, acc_cont;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             dir_err_d;
    logic             parity_err_d;
    logic             fifo_full, fifo_empty, pop;

    function automatic logic [WIDTH-1:0] shift_in(logic [WIDTH-1:0] a, logic b, dir_t d);
        if (d == DIR_MSB_FIRST) return {a[WIDTH-2:0], b};
        else                    return {b, a[WIDTH-1:1]};
    endfunction

    assign cur_dir  = dir_t'(dir_left);
    // acc_new starts a word in the incoming direction; acc_cont extends the current one.
    assign acc_new  = shift_in(acc_q, bit_in, cur_dir);
    assign acc_cont = shift_in(acc_q, bit_in, dir_q);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        push         = 1'b0;
        push_data    = acc_cont;
        dir_err_d    = 1'b0;
        parity_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && bit_valid) begin
                    acc_d   = acc_new;
                    cnt_d   = CW'(1);
                    dir_d   = cur_dir;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (bit_valid) begin
                    if (cur_dir != dir_q) begin
                        dir_err_d = 1'b1;
                        acc_d     = acc_new;
                        cnt_d     = CW'(1);
                        dir_d     = cur_dir;
                    end else begin
                        acc_d = acc_cont;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            cnt_d = '0;
`ifdef PARITY_CHECK_EN
                            state_d = ST_PARITY;
`else
                            push    = 1'b1;
                            state_d = ST_IDLE;
`endif
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PARITY: begin
                push_data = acc_q;
                if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (bit_valid) begin
                    if (cur_dir != dir_q) begin
                        dir_err_d = 1'b1;
                        acc_d     = acc_new;
                        cnt_d     = CW'(1);
                        dir_d     = cur_dir;
                        state_d   = ST_COLLECT;
                    end else begin
                        // Even parity: data bits plus parity bit XOR to zero.
                        if ((^acc_q ^ bit_in) == 1'b0) push = 1'b1;
                        else                           parity_err_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_LSB_FIRST;
            dir_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dir_err <= dir_err_d;
            // A drop on the same cycle as clr_flags keeps the flag set.
            if (push && fifo_full && !pop) overflow <= 1'b1;
            else if (clr_flags)            overflow <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_err <= 1'b0;
        else        parity_err <= parity_err_d;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign out_valid = ~fifo_empty;
    assign pop       = out_ready & ~fifo_empty;

    word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_data)
    );

endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       dir_left = 1'b0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       overflow;
    logic       dir_err;
    logic       parity_err;
    logic       clr_flags = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_word_collector #(.WIDTH(4), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .dir_left   (dir_left),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overflow   (overflow),
        .dir_err    (dir_err),
        .parity_err (parity_err),
        .clr_flags  (clr_flags)
    );

    typedef struct {
        logic [3:0] seq;   // seq[3] is sent first
        logic       dir;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; bit_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_bit(input logic b, input logic d);
        @(negedge clk);
        bit_valid = 1'b1; bit_in = b; dir_left = d;
        @(posedge clk);
        #1 bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] seq, input logic d);
        for (int i = 3; i >= 0; i--) send_bit(seq[i], d);
    endtask

    // Reference model state for the randomized phase.
    logic       m_bits[$];
    logic       m_dir;
    logic [3:0] m_fifo[$];
    logic       m_ovf;
    logic       m_dir_err;

    function automatic logic [3:0] assemble(input logic d);
        logic [3:0] w = 4'd0;
        for (int i = 0; i < 4; i++)
            if (m_bits[i]) w = w + (d ? 4'(1 << (3 - i)) : 4'(1 << i));
        return w;
    endfunction

    initial begin
        vecs[0] = '{seq: 4'b1011, dir: 1'b1, exp: 4'b1011};
        vecs[1] = '{seq: 4'b1011, dir: 1'b0, exp: 4'b1101};
        vecs[2] = '{seq: 4'b0001, dir: 1'b1, exp: 4'b0001};
        vecs[3] = '{seq: 4'b0001, dir: 1'b0, exp: 4'b1000};
        vecs[4] = '{seq: 4'b1110, dir: 1'b0, exp: 4'b0111};
        vecs[5] = '{seq: 4'b0110, dir: 1'b1, exp: 4'b0110};

        // Reset values
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_dir_err", 32'(dir_err), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        do_reset();

        // Table-driven single words, consumer always ready
        out_ready = 1'b1;
        foreach (vecs[k]) begin
            send_word(vecs[k].seq, vecs[k].dir);
            check($sformatf("vec%0d_valid", k), 32'(out_valid), 1);
            check($sformatf("vec%0d_data", k), 32'(out_data), 32'(vecs[k].exp));
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid_1cyc", k), 32'(out_valid), 0);
        end

        // Overflow: five words with consumer stalled
        do_reset();
        for (int w = 1; w <= 5; w++) send_word(4'(w), 1'b1);
        check("ovf_set", 32'(overflow), 1);
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            check($sformatf("ovf_pop%0d", w), 32'(out_data), 32'(w));
            out_ready = 1'b1;
            @(posedge clk); #1 out_ready = 1'b0;
        end
        check("ovf_drained", 32'(out_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);
        @(negedge clk) clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // Direction change mid-word
        do_reset();
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        check("dir_err_pulse", 32'(dir_err), 1);
        check("dir_err_no_word", 32'(out_valid), 0);
        send_bit(1'b0, 1'b0);
        check("dir_err_cleared", 32'(dir_err), 0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        check("dir_new_word_valid", 32'(out_valid), 1);
        check("dir_new_word_data", 32'(out_data), 32'h1);

        // Flush (with a simultaneous bit that must be ignored)
        do_reset();
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        @(negedge clk);
        flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; dir_left = 1'b1;
        @(posedge clk); #1 flush = 1'b0; bit_valid = 1'b0;
        send_word(4'hA, 1'b1);
        check("flush_valid", 32'(out_valid), 1);
        check("flush_data", 32'(out_data), 32'hA);
        @(posedge clk); #1;
        check("flush_only_one", 32'(out_valid), 0);

        // Async reset mid-word and mid-handshake
        do_reset();
        send_word(4'h5, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("areset_valid", 32'(out_valid), 0);
        check("areset_data", 32'(out_data), 0);
        @(negedge clk) reset = 1'b1;
        send_bit(1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1 check("areset_partial_lost", 32'(out_valid), 0);

        // Randomized run against the queue-based model
        do_reset();
        m_bits.delete(); m_fifo.delete();
        m_dir = 1'b0; m_ovf = 1'b0; m_dir_err = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic r_bv, r_bit, r_dir, r_fl, r_rdy, r_clr, popped;
            @(negedge clk);
            check("rnd_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) check("rnd_data", 32'(out_data), 32'(m_fifo[0]));
            check("rnd_overflow", 32'(overflow), 32'(m_ovf));
            check("rnd_dir_err", 32'(dir_err), 32'(m_dir_err));
            check("rnd_parity_err", 32'(parity_err), 0);

            r_bv  = ($urandom_range(0, 99) < 60);
            r_bit = 1'($urandom);
            r_dir = ($urandom_range(0, 99) < 8) ? ~m_dir : m_dir;
            r_fl  = ($urandom_range(0, 99) < 3);
            r_rdy = ($urandom_range(0, 99) < 35);
            r_clr = ($urandom_range(0, 99) < 4);
            bit_valid = r_bv; bit_in = r_bit; dir_left = r_dir;
            flush = r_fl; out_ready = r_rdy; clr_flags = r_clr;

            popped = 1'b0;
            if (r_rdy && m_fifo.size() != 0) begin
                void'(m_fifo.pop_front());
                popped = 1'b1;
            end
            m_dir_err = 1'b0;
            if (r_fl) begin
                m_bits.delete();
                if (r_clr) m_ovf = 1'b0;
            end else begin
                logic dropped = 1'b0;
                if (r_bv) begin
                    if (m_bits.size() != 0 && r_dir != m_dir) begin
                        m_dir_err = 1'b1;
                        m_bits.delete();
                    end
                    if (m_bits.size() == 0) m_dir = r_dir;
                    m_bits.push_back(r_bit);
                    if (m_bits.size() == 4) begin
                        if (m_fifo.size() < 4) m_fifo.push_back(assemble(m_dir));
                        else dropped = 1'b1;
                        m_bits.delete();
                    end
                end
                if (dropped)    m_ovf = 1'b1;
                else if (r_clr) m_ovf = 1'b0;
            end
            // A pop frees space before the push in the same cycle.
            if (popped) begin end
        end
        @(negedge clk);
        bit_valid = 1'b0; flush = 1'b0; clr_flags = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
